// File: rtl/fighting_game_arena_pkg.sv
// Shared definitions for the fighting-game arena: action codes, FSM states,
// and the round-start position helper.
// Combinational only; no latency, no flow control.
package fg_pkg;

  localparam logic [2:0] ACT_IDLE  = 3'b000;
  localparam logic [2:0] ACT_PUNCH = 3'b001;
  localparam logic [2:0] ACT_KICK  = 3'b010;
  localparam logic [2:0] ACT_BLOCK = 3'b011;
  localparam logic [2:0] ACT_FWD   = 3'b100;
  localparam logic [2:0] ACT_BACK  = 3'b101;
  localparam logic [2:0] ACT_JUMP  = 3'b110;
  localparam logic [2:0] ACT_RSVD  = 3'b111;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_RESOLVE,
    ST_UPDATE,
    ST_CHECK,
    ST_MATCH_OVER
  } fsm_state_t;

  // Round-start position: P1 one step off the left wall, P2 one off the right.
  function automatic int start_pos(input int arena_pos, input logic player2);
    return player2 ? arena_pos - 2 : 1;
  endfunction

endpackage

// File: rtl/fighting_game_arena_if.sv
// Player-action / scoreboard bundle between the switch front-end and the arena.
// No latency of its own; actionEnable is a level whose rising edge requests a turn.
// No backpressure: edges arriving while a turn is in flight are dropped.
// Ports: action1/2, actionEnable (to engine); health, pos, state, roundWins,
//        firstWin/secondWin, turnDone (from engine).
interface fighting_game_arena_if #(
  parameter int HW = 2,
  parameter int PW = 3,
  parameter int RW = 2
);
  logic [2:0]    action1;
  logic [2:0]    action2;
  logic          actionEnable;
  logic [HW-1:0] health1;
  logic [HW-1:0] health2;
  logic [PW-1:0] pos1;
  logic [PW-1:0] pos2;
  logic [2:0]    state1;
  logic [2:0]    state2;
  logic [RW-1:0] roundWins1;
  logic [RW-1:0] roundWins2;
  logic          firstWin;
  logic          secondWin;
  logic          turnDone;

  modport master (
    output action1, action2, actionEnable,
    input  health1, health2, pos1, pos2, state1, state2,
           roundWins1, roundWins2, firstWin, secondWin, turnDone
  );

  modport slave (
    input  action1, action2, actionEnable,
    output health1, health2, pos1, pos2, state1, state2,
           roundWins1, roundWins2, firstWin, secondWin, turnDone
  );
endinterface

// File: rtl/fighting_game_arena_hit_resolver.sv
// Damage one attacker deals to one defender at a given post-move distance.
// Purely combinational, zero latency.
// No flow control; the caller registers the result.
// Ports: i_atk/i_def action codes, i_dist distance, i_cool kick cooldown, o_dmg.
module fg_hit_resolver
  import fg_pkg::*;
#(
  parameter int PW          = 3,
  parameter int PUNCH_DMG   = 1,
  parameter int KICK_DMG    = 2,
  parameter int PUNCH_REACH = 1,
  parameter int KICK_REACH  = 2
) (
  input  logic [2:0]    i_atk,
  input  logic [2:0]    i_def,
  input  logic [PW-1:0] i_dist,
  input  logic          i_cool,
  output logic [7:0]    o_dmg
);

  always_comb begin
    o_dmg = 8'd0;
    if (i_atk == ACT_PUNCH && int'(i_dist) <= PUNCH_REACH) begin
      if (i_def != ACT_BLOCK) o_dmg = 8'(PUNCH_DMG);
    end else if (i_atk == ACT_KICK && !i_cool && int'(i_dist) <= KICK_REACH) begin
      // A block only softens a kick; a jump dodges it entirely.
      if (i_def == ACT_BLOCK)     o_dmg = 8'(KICK_DMG - 1);
      else if (i_def != ACT_JUMP) o_dmg = 8'(KICK_DMG);
    end
  end

endmodule

// File: rtl/fighting_game_arena.sv
// Two-player turn engine: movement, attacks, cooldown, health and round scoring.
// Turn latency: results at E+2 (turnDone pulse), round/match bookkeeping at E+3.
// No queueing: enable edges outside WAIT are dropped; MATCH_OVER ignores all.
// Ports: clk, resetGame (async, active high), bus (slave side of the arena bundle).
module fighting_game_arena
  import fg_pkg::*;
#(
  parameter int MAX_HEALTH    = 3,
  parameter int ARENA_POS     = 8,
  parameter int PUNCH_DMG     = 1,
  parameter int KICK_DMG      = 2,
  parameter int PUNCH_REACH   = 1,
  parameter int KICK_REACH    = 2,
  parameter int KICK_COOLDOWN = 1,
  parameter int ROUNDS_TO_WIN = 2
) (
  input  logic                 clk,
  input  logic                 resetGame,
  fighting_game_arena_if.slave bus
);

  localparam int HW = $clog2(MAX_HEALTH + 1);
  localparam int PW = $clog2(ARENA_POS);
  localparam int RW = $clog2(ROUNDS_TO_WIN + 1);
  localparam int CW = (KICK_COOLDOWN > 0) ? $clog2(KICK_COOLDOWN + 1) : 1;

  localparam logic [HW-1:0] HMAX     = HW'(MAX_HEALTH);
  localparam logic [PW-1:0] P1_START = PW'(start_pos(ARENA_POS, 1'b0));
  localparam logic [PW-1:0] P2_START = PW'(start_pos(ARENA_POS, 1'b1));
  localparam logic [PW-1:0] POS_MAX  = PW'(ARENA_POS - 1);
  localparam logic [PW-1:0] P_ONE    = PW'(1);
  localparam logic [PW-1:0] P_TWO    = PW'(2);
  localparam logic [PW-1:0] P_THREE  = PW'(3);
  localparam logic [RW-1:0] WIN_TGT  = RW'(ROUNDS_TO_WIN);
  localparam logic [CW-1:0] CD_LOAD  = CW'(KICK_COOLDOWN);

  fsm_state_t    r_fsm, w_fsm_nxt;
  logic          r_en_prev, r_done, r_first, r_second;
  logic [2:0]    r_act1, r_act2, r_eff1, r_eff2, r_state1, r_state2;
  logic [PW-1:0] r_pos1, r_pos2, r_npos1, r_npos2;
  logic [HW-1:0] r_health1, r_health2;
  logic [7:0]    r_dmg1, r_dmg2;   // damage taken by P1 / P2 this turn
  logic [CW-1:0] r_cd1, r_cd2;
  logic [RW-1:0] r_wins1, r_wins2;

  logic          w_start, w_ko1, w_ko2, w_win1, w_win2, w_fin1, w_fin2;
  logic [2:0]    w_eff1, w_eff2;
  logic [PW-1:0] w_dist0, w_dist, w_npos1, w_npos2;
  logic [7:0]    w_dmg1, w_dmg2;

  function automatic logic [HW-1:0] sat_sub(input logic [HW-1:0] h, input logic [7:0] d);
    int diff;
    diff = int'(h) - int'(d);
    return (diff <= 0) ? '0 : diff[HW-1:0];
  endfunction

  assign w_start = (r_fsm == ST_WAIT) && bus.actionEnable && !r_en_prev;

  // Reserved code and a kick still cooling down both behave as IDLE.
  assign w_eff1 = (r_act1 == ACT_RSVD || (r_act1 == ACT_KICK && r_cd1 != '0)) ? ACT_IDLE : r_act1;
  assign w_eff2 = (r_act2 == ACT_RSVD || (r_act2 == ACT_KICK && r_cd2 != '0)) ? ACT_IDLE : r_act2;

  // Movement. A lone FWD is judged against the pre-move gap; a mutual FWD
  // gives P1 priority for the last free square.
  always_comb begin
    w_dist0 = r_pos2 - r_pos1;
    w_npos1 = r_pos1;
    w_npos2 = r_pos2;
    if (w_eff1 == ACT_FWD && w_eff2 == ACT_FWD) begin
      if (w_dist0 >= P_THREE) begin
        w_npos1 = r_pos1 + P_ONE;
        w_npos2 = r_pos2 - P_ONE;
      end else if (w_dist0 == P_TWO) begin
        w_npos1 = r_pos1 + P_ONE;
      end
    end else begin
      if (w_eff1 == ACT_FWD && w_dist0 >= P_TWO)      w_npos1 = r_pos1 + P_ONE;
      if (w_eff1 == ACT_BACK && r_pos1 != '0)         w_npos1 = r_pos1 - P_ONE;
      if (w_eff2 == ACT_FWD && w_dist0 >= P_TWO)      w_npos2 = r_pos2 - P_ONE;
      if (w_eff2 == ACT_BACK && r_pos2 != POS_MAX)    w_npos2 = r_pos2 + P_ONE;
    end
  end

  assign w_dist = w_npos2 - w_npos1;

  fg_hit_resolver #(
    .PW(PW), .PUNCH_DMG(PUNCH_DMG), .KICK_DMG(KICK_DMG),
    .PUNCH_REACH(PUNCH_REACH), .KICK_REACH(KICK_REACH)
  ) u_hit_p1_to_p2 (
    .i_atk(r_act1), .i_def(w_eff2), .i_dist(w_dist), .i_cool(r_cd1 != '0), .o_dmg(w_dmg2)
  );

  fg_hit_resolver #(
    .PW(PW), .PUNCH_DMG(PUNCH_DMG), .KICK_DMG(KICK_DMG),
    .PUNCH_REACH(PUNCH_REACH), .KICK_REACH(KICK_REACH)
  ) u_hit_p2_to_p1 (
    .i_atk(r_act2), .i_def(w_eff1), .i_dist(w_dist), .i_cool(r_cd2 != '0), .o_dmg(w_dmg1)
  );

  // Round bookkeeping, evaluated in CHECK on the freshly updated health.
  assign w_ko1  = (r_health1 == '0);
  assign w_ko2  = (r_health2 == '0);
  assign w_win1 = w_ko2 && !w_ko1;
  assign w_win2 = w_ko1 && !w_ko2;
  assign w_fin1 = w_win1 && ((r_wins1 + RW'(1)) == WIN_TGT);
  assign w_fin2 = w_win2 && ((r_wins2 + RW'(1)) == WIN_TGT);

  always_ff @(posedge clk or posedge resetGame) begin
    if (resetGame) r_fsm <= ST_WAIT;
    else           r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_WAIT:       if (w_start) w_fsm_nxt = ST_RESOLVE;
      ST_RESOLVE:    w_fsm_nxt = ST_UPDATE;
      ST_UPDATE:     w_fsm_nxt = ST_CHECK;
      ST_CHECK:      w_fsm_nxt = (w_fin1 || w_fin2) ? ST_MATCH_OVER : ST_WAIT;
      ST_MATCH_OVER: w_fsm_nxt = ST_MATCH_OVER;
      default:       w_fsm_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge resetGame) begin
    if (resetGame) begin
      // enPrev starts high so an enable held through reset is not an edge.
      r_en_prev <= 1'b1;
      r_done    <= 1'b0;
      r_first   <= 1'b0;
      r_second  <= 1'b0;
      r_act1    <= ACT_IDLE;
      r_act2    <= ACT_IDLE;
      r_eff1    <= ACT_IDLE;
      r_eff2    <= ACT_IDLE;
      r_state1  <= ACT_IDLE;
      r_state2  <= ACT_IDLE;
      r_pos1    <= P1_START;
      r_pos2    <= P2_START;
      r_npos1   <= P1_START;
      r_npos2   <= P2_START;
      r_health1 <= HMAX;
      r_health2 <= HMAX;
      r_dmg1    <= 8'd0;
      r_dmg2    <= 8'd0;
      r_cd1     <= '0;
      r_cd2     <= '0;
      r_wins1   <= '0;
      r_wins2   <= '0;
    end else begin
      r_en_prev <= bus.actionEnable;
      r_done    <= 1'b0;
      case (r_fsm)
        ST_WAIT: begin
          if (w_start) begin
            r_act1 <= bus.action1;
            r_act2 <= bus.action2;
          end
        end
        ST_RESOLVE: begin
          r_eff1  <= w_eff1;
          r_eff2  <= w_eff2;
          r_npos1 <= w_npos1;
          r_npos2 <= w_npos2;
          r_dmg1  <= w_dmg1;
          r_dmg2  <= w_dmg2;
          if (w_eff1 == ACT_KICK)  r_cd1 <= CD_LOAD;
          else if (r_cd1 != '0)    r_cd1 <= r_cd1 - CW'(1);
          if (w_eff2 == ACT_KICK)  r_cd2 <= CD_LOAD;
          else if (r_cd2 != '0)    r_cd2 <= r_cd2 - CW'(1);
        end
        ST_UPDATE: begin
          r_health1 <= sat_sub(r_health1, r_dmg1);
          r_health2 <= sat_sub(r_health2, r_dmg2);
          r_pos1    <= r_npos1;
          r_pos2    <= r_npos2;
          r_state1  <= r_eff1;
          r_state2  <= r_eff2;
          r_done    <= 1'b1;
        end
        ST_CHECK: begin
          if (w_win1) r_wins1 <= r_wins1 + RW'(1);
          if (w_win2) r_wins2 <= r_wins2 + RW'(1);
          if (w_fin1) r_first  <= 1'b1;
          if (w_fin2) r_second <= 1'b1;
          // A KO that does not end the match starts a fresh round; a
          // match-ending KO leaves the final health on display.
          if ((w_ko1 || w_ko2) && !(w_fin1 || w_fin2)) begin
            r_health1 <= HMAX;
            r_health2 <= HMAX;
            r_pos1    <= P1_START;
            r_pos2    <= P2_START;
            r_cd1     <= '0;
            r_cd2     <= '0;
            r_state1  <= ACT_IDLE;
            r_state2  <= ACT_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.health1    = r_health1;
  assign bus.health2    = r_health2;
  assign bus.pos1       = r_pos1;
  assign bus.pos2       = r_pos2;
  assign bus.state1     = r_state1;
  assign bus.state2     = r_state2;
  assign bus.roundWins1 = r_wins1;
  assign bus.roundWins2 = r_wins2;
  assign bus.firstWin   = r_first;
  assign bus.secondWin  = r_second;
  assign bus.turnDone   = r_done;

endmodule
